// File: rtl/pram_port_arbiter.sv
// ---------------------------------------------------------------------------
// pram_port_arbiter
//
// Shares one single-port program RAM between an on-chip debugger (OCD) and
// the CPU. Grants are combinational in the request cycle. The RAM strobe is
// registered one cycle later. Read data returns to the owner one cycle after
// that.
//
// Arbitration rules:
//   - OCD has priority.
//   - A CPU that has lost MAX_WAIT consecutive cycles is forced a grant.
//   - When the debugger raises ocd_lock, the arbiter stops granting and
//     waits for outstanding CPU reads to drain. It then gives the OCD
//     exclusive ownership until ocd_lock falls.
//
// Ports:
//   clk, sync_reset                      clock, synchronous active-high reset
//   ocd_req/we/addr/wdata                OCD request channel
//   ocd_gnt, ocd_rvalid, ocd_rdata       OCD grant and read return
//   cpu_req/we/addr/wdata/be             CPU request channel
//   cpu_gnt, cpu_rvalid, cpu_rdata       CPU grant and read return
//   ocd_lock, ocd_lock_ack               exclusive-ownership handshake
//   mem_en/we/addr/wdata/be, mem_rdata   program RAM port
// ---------------------------------------------------------------------------
module pram_port_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  sync_reset,

    input  logic                  ocd_req,
    input  logic                  ocd_we,
    input  logic [ADDR_WIDTH-1:0] ocd_addr,
    input  logic [DATA_WIDTH-1:0] ocd_wdata,
    output logic                  ocd_gnt,
    output logic                  ocd_rvalid,
    output logic [DATA_WIDTH-1:0] ocd_rdata,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [3:0]            cpu_be,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,

    input  logic                  ocd_lock,
    output logic                  ocd_lock_ack,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] ST_OPEN   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [1:0] state, state_nxt;
    logic [3:0] wait_cnt, wait_nxt;

    // Read-in-flight flags for the T+1 (RAM access) stage.
    logic s1_ocd_rd;
    logic s1_cpu_rd;
    logic cpu_rd_in_flight;

    // Both T+1 and T+2 stages count as in flight. Draining stops only after
    // the CPU has seen its rvalid.
    assign cpu_rd_in_flight = s1_cpu_rd | cpu_rvalid;

    // Grant decision.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        ocd_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (!sync_reset) begin
            case (state)
                ST_OPEN: begin
                    // The cycle that sees ocd_lock issues no grant. This
                    // prevents a new CPU read from slipping in behind the drain.
                    if (!ocd_lock) begin
                        if (ocd_req && !(cpu_req && wait_cnt == WAIT_MAX))
                            ocd_gnt = 1'b1;
                        else if (cpu_req)
                            cpu_gnt = 1'b1;
                    end
                end
                // The unlock cycle grants nothing. Arbitration resumes in OPEN.
                ST_LOCKED: ocd_gnt = ocd_req && ocd_lock;
                default: ;
            endcase
        end
    end

    // Next state and starvation counter.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_OPEN:   if (ocd_lock) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!ocd_lock)
                    state_nxt = ST_OPEN;
                else if (!cpu_rd_in_flight)
                    state_nxt = ST_LOCKED;
            end
            ST_LOCKED: if (!ocd_lock) state_nxt = ST_OPEN;
            default:   state_nxt = ST_OPEN;
        endcase

        wait_nxt = wait_cnt;
        if (state == ST_LOCKED || !cpu_req || cpu_gnt)
            wait_nxt = 4'd0;
        else if (state == ST_OPEN && wait_cnt < WAIT_MAX)
            wait_nxt = wait_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state        <= ST_OPEN;
            wait_cnt     <= 4'd0;
            s1_ocd_rd    <= 1'b0;
            s1_cpu_rd    <= 1'b0;
            ocd_rvalid   <= 1'b0;
            cpu_rvalid   <= 1'b0;
            ocd_lock_ack <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= 4'h0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_nxt;
            // Registered from the next state, so it is high exactly while in LOCKED.
            ocd_lock_ack <= (state_nxt == ST_LOCKED);

            s1_ocd_rd    <= ocd_gnt & ~ocd_we;
            s1_cpu_rd    <= cpu_gnt & ~cpu_we;
            ocd_rvalid   <= s1_ocd_rd;
            cpu_rvalid   <= s1_cpu_rd;

            if (ocd_gnt) begin
                mem_en    <= 1'b1;
                mem_we    <= ocd_we;
                mem_addr  <= ocd_addr;
                mem_wdata <= ocd_wdata;
                mem_be    <= 4'hF;
            end else if (cpu_gnt) begin
                mem_en    <= 1'b1;
                mem_we    <= cpu_we;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
                mem_be    <= cpu_be;
            end else begin
                // Address and data hold their last value. Only the strobes drop.
                mem_en    <= 1'b0;
                mem_we    <= 1'b0;
            end
        end
    end

    // The RAM has a single read bus. rvalid tells each side when it is theirs.
    assign ocd_rdata = mem_rdata;
    assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_pram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pram_port_arbiter
//
// Directed testbench for pram_port_arbiter. A behavioural RAM with one-cycle
// read latency sits on the mem_* port.
//
// Timing: inputs change 1 time unit after a rising edge, and outputs are
// sampled on the falling edge. "Cycle T" is therefore the interval between
// two rising edges.
// ---------------------------------------------------------------------------
module tb_pram_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic          ocd_req, ocd_we;
    logic [AW-1:0] ocd_addr;
    logic [DW-1:0] ocd_wdata;
    logic          ocd_gnt, ocd_rvalid;
    logic [DW-1:0] ocd_rdata;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [3:0]    cpu_be;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ocd_lock, ocd_lock_ack;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .sync_reset(sync_reset),
        .ocd_req(ocd_req), .ocd_we(ocd_we), .ocd_addr(ocd_addr), .ocd_wdata(ocd_wdata),
        .ocd_gnt(ocd_gnt), .ocd_rvalid(ocd_rvalid), .ocd_rdata(ocd_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ocd_lock(ocd_lock), .ocd_lock_ack(ocd_lock_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    // Behavioural program RAM: byte-enabled writes and a one-cycle read.
    logic [DW-1:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[7:0]];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge (input-drive point).
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    logic found;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[8'h10] = 32'h1234_5678;
        ram[8'h30] = 32'h3030_3030;
        for (int i = 0; i < 8; i++) ram[i] = 32'hA000_0000 + i;
        mem_rdata = '0;

        // Reset with both requesters active: no grant may appear.
        sync_reset = 1'b1;
        ocd_req = 1'b1; ocd_we = 1'b0; ocd_addr = '0; ocd_wdata = '0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = 4'h0;
        ocd_lock = 1'b0;
        next_cycle();
        @(negedge clk);
        check("rst_ocd_gnt", ocd_gnt, 0);
        check("rst_cpu_gnt", cpu_gnt, 0);
        next_cycle();
        sync_reset = 1'b0; ocd_req = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_ocd_rvalid", ocd_rvalid, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_lock_ack", ocd_lock_ack, 0);

        // OCD read of 0x0010.
        next_cycle();
        ocd_req = 1'b1; ocd_we = 1'b0; ocd_addr = 14'h0010;
        @(negedge clk);
        check("ocdrd_gnt", ocd_gnt, 1);
        check("ocdrd_cpu_gnt", cpu_gnt, 0);
        next_cycle();
        ocd_req = 1'b0;
        @(negedge clk);
        check("ocdrd_mem_en", mem_en, 1);
        check("ocdrd_mem_we", mem_we, 0);
        check("ocdrd_mem_addr", mem_addr, 14'h0010);
        check("ocdrd_mem_be", mem_be, 4'hF);
        check("ocdrd_early_rvalid", ocd_rvalid, 0);
        next_cycle();
        @(negedge clk);
        check("ocdrd_rvalid", ocd_rvalid, 1);
        check("ocdrd_rdata", ocd_rdata, 32'h1234_5678);
        check("ocdrd_cpu_rvalid", cpu_rvalid, 0);
        next_cycle();
        @(negedge clk);
        check("ocdrd_rvalid_pulse", ocd_rvalid, 0);

        // CPU partial write of 0x0020, then read it back.
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0020; cpu_wdata = 32'hDEAD_BEEF; cpu_be = 4'b0011;
        @(negedge clk);
        check("cpuwr_gnt", cpu_gnt, 1);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check("cpuwr_mem_en", mem_en, 1);
        check("cpuwr_mem_we", mem_we, 1);
        check("cpuwr_mem_be", mem_be, 4'b0011);
        check("cpuwr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("cpuwr_mem_addr", mem_addr, 14'h0020);
        next_cycle();
        @(negedge clk);
        check("cpuwr_no_cpu_rvalid", cpu_rvalid, 0);
        check("cpuwr_no_ocd_rvalid", ocd_rvalid, 0);
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF;
        @(negedge clk);
        check("cpurd_gnt", cpu_gnt, 1);
        next_cycle();
        cpu_req = 1'b0;
        next_cycle();
        @(negedge clk);
        check("cpurd_rvalid", cpu_rvalid, 1);
        check("cpurd_rdata", cpu_rdata, 32'h0000_BEEF);
        idle(2);

        // Both requesters continuously: OCD x4 then CPU, repeating.
        ocd_req = 1'b1; ocd_we = 1'b0; ocd_addr = 14'h0010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0030;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("fair_ocd_%0d", i), ocd_gnt, (i % 5 != 4));
            check($sformatf("fair_cpu_%0d", i), cpu_gnt, (i % 5 == 4));
            next_cycle();
        end
        ocd_req = 1'b0; cpu_req = 1'b0;
        idle(3);

        // Lock while a CPU read is in flight.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0030;
        @(negedge clk);
        check("lock_cpu_gnt", cpu_gnt, 1);
        next_cycle();
        cpu_addr = 14'h0031; ocd_lock = 1'b1;
        @(negedge clk);
        check("lock_open_no_gnt", cpu_gnt, 0);
        next_cycle();
        @(negedge clk);
        check("lock_cpu_rvalid", cpu_rvalid, 1);
        check("lock_cpu_rdata", cpu_rdata, 32'h3030_3030);
        check("lock_ack_early", ocd_lock_ack, 0);
        check("lock_drain_no_gnt", cpu_gnt, 0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("lock_wait_cpu_gnt_%0d", i), cpu_gnt, 0);
            if (ocd_lock_ack) found = 1'b1;
        end
        check("lock_ack_reached", found, 1);
        next_cycle();
        ocd_req = 1'b1; ocd_we = 1'b0; ocd_addr = 14'h0010;
        @(negedge clk);
        check("locked_ocd_gnt", ocd_gnt, 1);
        check("locked_cpu_gnt", cpu_gnt, 0);
        next_cycle();
        ocd_req = 1'b0; ocd_lock = 1'b0;
        @(negedge clk);
        check("unlock_cycle_cpu_gnt", cpu_gnt, 0);
        check("unlock_cycle_ack", ocd_lock_ack, 1);
        next_cycle();
        @(negedge clk);
        check("reopen_cpu_gnt", cpu_gnt, 1);
        check("reopen_ack", ocd_lock_ack, 0);
        check("locked_ocd_rvalid", ocd_rvalid, 1);
        check("locked_ocd_rdata", ocd_rdata, 32'h1234_5678);
        next_cycle();
        cpu_req = 1'b0;
        idle(3);

        // Reset one cycle after an OCD read grant drops the read.
        ocd_req = 1'b1; ocd_we = 1'b0; ocd_addr = 14'h0010;
        @(negedge clk);
        check("rstfl_gnt", ocd_gnt, 1);
        next_cycle();
        ocd_req = 1'b0; sync_reset = 1'b1;
        @(negedge clk);
        check("rstfl_mem_en_pre", mem_en, 1);
        next_cycle();
        sync_reset = 1'b0;
        @(negedge clk);
        check("rstfl_ocd_rvalid", ocd_rvalid, 0);
        check("rstfl_mem_en", mem_en, 0);
        check("rstfl_mem_we", mem_we, 0);
        check("rstfl_mem_addr", mem_addr, 0);
        check("rstfl_mem_wdata", mem_wdata, 0);
        check("rstfl_mem_be", mem_be, 0);
        check("rstfl_ack", ocd_lock_ack, 0);
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0005;
        @(negedge clk);
        check("rstfl_ocd_rvalid_late", ocd_rvalid, 0);
        check("rstfl_open_cpu_gnt", cpu_gnt, 1);
        next_cycle();
        cpu_req = 1'b0;
        idle(3);

        // Eight back-to-back OCD reads of addresses 0..7.
        for (int k = 0; k < 10; k++) begin
            ocd_req = (k < 8); ocd_we = 1'b0; ocd_addr = 14'(k % 8);
            @(negedge clk);
            if (k < 8) check($sformatf("b2b_gnt_%0d", k), ocd_gnt, 1);
            if (k >= 1 && k <= 8) begin
                check($sformatf("b2b_mem_en_%0d", k), mem_en, 1);
                check($sformatf("b2b_mem_addr_%0d", k), mem_addr, k - 1);
            end
            if (k >= 2) begin
                check($sformatf("b2b_rvalid_%0d", k), ocd_rvalid, 1);
                check($sformatf("b2b_rdata_%0d", k), ocd_rdata, 32'hA000_0000 + k - 2);
            end
            next_cycle();
        end
        ocd_req = 1'b0;
        @(negedge clk);
        check("b2b_rvalid_end", ocd_rvalid, 0);
        check("b2b_mem_en_end", mem_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pram_port_arbiter.md
PRAM_PORT_ARBITER -- requirements
Module: pram_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, SHALL be the word-address width of the program RAM port.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL be the data word width.
REQ-003 Parameter MAX_WAIT, default 4, SHALL be the number of consecutive CPU losses before the CPU is forced a grant (range 1..15).
REQ-004 Ports SHALL be:
- clk  in  1  sole clock, rising edge
- sync_reset  in  1  synchronous reset, active-high
- ocd_req / ocd_we  in  1 / 1  OCD access request / write select
- ocd_addr / ocd_wdata  in  ADDR_WIDTH / DATA_WIDTH  OCD address / write data
- ocd_gnt / ocd_rvalid  out  1 / 1  OCD grant / read data valid
- ocd_rdata  out  DATA_WIDTH  OCD read data
- cpu_req / cpu_we  in  1 / 1  CPU access request / write select
- cpu_addr / cpu_wdata / cpu_be  in  ADDR_WIDTH / DATA_WIDTH / 4  CPU address / write data / byte enables
- cpu_gnt / cpu_rvalid  out  1 / 1  CPU grant / read data valid
- cpu_rdata  out  DATA_WIDTH  CPU read data
- ocd_lock  in  1  OCD requests exclusive ownership (debug session active)
- ocd_lock_ack  out  1  exclusive ownership in effect
- mem_en / mem_we  out  1 / 1  RAM access strobe / write
- mem_addr / mem_wdata / mem_be  out  ADDR_WIDTH / DATA_WIDTH / 4  RAM address / data / byte enables
- mem_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after mem_en with mem_we=0

Function
REQ-005 Grants SHALL be combinational in cycle T from req, state and wait counter; at most one of ocd_gnt, cpu_gnt high per cycle; both low while sync_reset=1.
REQ-006 A requester SHALL hold req, we, addr, wdata, be stable until its gnt is sampled high; a gnt with req low SHALL never occur.
REQ-007 mem_en, mem_we, mem_addr, mem_wdata, mem_be SHALL be registered: the granted request appears at T+1; mem_en=0 in cycles following no grant.
REQ-008 OCD accesses SHALL drive mem_be=4'hF; CPU accesses SHALL pass cpu_be.
REQ-009 Granted reads SHALL assert the owner's rvalid for exactly one cycle at T+2; writes SHALL produce no rvalid.
REQ-010 ocd_rdata and cpu_rdata SHALL both equal mem_rdata combinationally; contents are meaningful only while the respective rvalid is high.
REQ-011 Back-to-back grants SHALL be allowed every cycle; throughput one access per cycle.
REQ-012 State machine states: OPEN, DRAIN, LOCKED.
REQ-013 OPEN: OCD-only request -> OCD granted; CPU-only -> CPU granted; both -> OCD granted unless wait_cnt==MAX_WAIT, then CPU granted.
REQ-014 wait_cnt SHALL increment (saturating at MAX_WAIT) each cycle cpu_req=1 and cpu_gnt=0 in OPEN, and clear when cpu_gnt=1 or cpu_req=0.
REQ-015 OPEN -> DRAIN when ocd_lock=1; no grant issued in that cycle or in DRAIN.
REQ-016 DRAIN -> LOCKED when no CPU read is in flight (T+1 or T+2 stages); DRAIN -> OPEN if ocd_lock falls first.
REQ-017 LOCKED: only OCD granted; cpu_gnt=0; wait_cnt held at 0; ocd_lock_ack=1 (registered, high only in LOCKED).
REQ-018 LOCKED -> OPEN when ocd_lock=0; grants resume next cycle.

Reset
REQ-019 sync_reset=1 at a clock edge SHALL set state OPEN, wait_cnt 0, clear both pipeline stages, and drive mem_en, mem_we, mem_addr, mem_wdata, mem_be, ocd_rvalid, cpu_rvalid, ocd_lock_ack to 0 in the following cycle.
REQ-020 Reads in flight when reset is applied SHALL be dropped: no rvalid for them after reset.

Verification
REQ-021 OCD read addr 0x0010, RAM word 0x12345678 -> ocd_gnt at T, mem_en=1/mem_we=0/addr 0x0010 at T+1, ocd_rvalid=1 with ocd_rdata 0x12345678 at T+2, cpu_rvalid stays 0.
REQ-022 CPU write addr 0x0020, data 0xDEADBEEF, be 4'b0011 -> cpu_gnt at T, mem_we=1, mem_be=4'b0011 at T+1, no rvalid.
REQ-023 Both request continuously, MAX_WAIT=4 -> grant sequence OCD,OCD,OCD,OCD,CPU repeating.
REQ-024 CPU read granted at T, ocd_lock raised at T+1 -> DRAIN, cpu_rvalid at T+2, LOCKED and ocd_lock_ack=1 at T+3 or later; cpu_req then never granted until ocd_lock=0.
REQ-025 sync_reset pulsed one cycle after an OCD read grant -> no ocd_rvalid, all mem outputs 0, state OPEN.
REQ-026 OCD reads every cycle for 8 cycles, addr 0..7 -> eight consecutive mem_en cycles, eight consecutive ocd_rvalid pulses in address order.
